// File: rtl/fifo_pack.sv
// fifo_pack: half-word-in, full-word-out FIFO.
//
// Two consecutive accepted half-word writes are packed (upper half first)
// into one DATA_WIDTH word and committed to a DEPTH-entry circular store.
// Reads pop whole words; r_data shows the head word combinationally.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   wr            write request for one half-word
//   w_data        half-word to write (DATA_WIDTH/2 bits)
//   rd            read request, pops one full word
//   r_data        head word (valid while empty=0)
//   empty         no committed word present
//   full          DEPTH committed words present
//   half_pending  an upper half is staged, awaiting its lower half
//   count         committed words, 0..DEPTH
module fifo_pack #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [DATA_WIDTH/2-1:0] w_data,
  input  logic                    rd,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic                    empty,
  output logic                    full,
  output logic                    half_pending,
  output logic [ADDR_WIDTH:0]     count
);

  localparam int HALF  = DATA_WIDTH / 2;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [HALF-1:0]       staging;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;

  logic                  rd_ok;
  logic                  stage_ok;
  logic                  commit_ok;
  logic [ADDR_WIDTH:0]   count_next;

  // A commit into a full store is allowed only when a pop frees a slot
  // on the same edge.
  always_comb begin
    rd_ok      = rd && !empty;
    stage_ok   = wr && !half_pending;
    commit_ok  = wr && half_pending && (!full || rd_ok);
    count_next = count;
    if (commit_ok && !rd_ok)
      count_next = count + 1'b1;
    else if (rd_ok && !commit_ok)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      half_pending <= 1'b0;
      staging      <= '0;
    end else begin
      if (stage_ok) begin
        staging      <= w_data;
        half_pending <= 1'b1;
      end
      if (commit_ok) begin
        wr_ptr       <= wr_ptr + 1'b1;
        half_pending <= 1'b0;
      end
      if (rd_ok)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      // Flags are registered from the next count so they track it exactly.
      empty <= (count_next == '0);
      full  <= (count_next == FULL_COUNT);
    end
  end

  // Storage is deliberately not reset; writes are blocked while in reset.
  always_ff @(posedge clk) begin
    if (!reset && commit_ok)
      mem[wr_ptr] <= {staging, w_data};
  end

  assign r_data = mem[rd_ptr];

endmodule

// File: doc/fifo_pack.md
FIFO_PACK -- requirements
Module: fifo_pack

Interface
REQ-001: Parameter DATA_WIDTH, default 8, SHALL set the read-word width; it is even, and the write width is DATA_WIDTH/2.
REQ-002: Parameter ADDR_WIDTH, default 4, SHALL set the storage depth: DEPTH = 2**ADDR_WIDTH words.
REQ-003: clk  input  1  rising-edge clock for all state.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: wr  input  1  write request for one half-word.
REQ-006: w_data  input  DATA_WIDTH/2  half-word to write.
REQ-007: rd  input  1  read request that pops one full word.
REQ-008: r_data  output  DATA_WIDTH  word at the head of the queue.
REQ-009: empty  output  1  no committed word is present.
REQ-010: full  output  1  DEPTH committed words are present.
REQ-011: half_pending  output  1  an upper half is staged and awaits its lower half.
REQ-012: count  output  ADDR_WIDTH+1  number of committed words, 0..DEPTH.

Function
REQ-013: The block SHALL contain the DEPTH x DATA_WIDTH storage array, a half-word staging register, rd_ptr, wr_ptr, count, and the half_pending flag.
REQ-014: Pack order SHALL be upper first: the first accepted half-word goes to bits [DATA_WIDTH-1:DATA_WIDTH/2], and the second goes to [DATA_WIDTH/2-1:0].
REQ-015: A write with half_pending=0 SHALL always be accepted, even when full; it loads the staging register and sets half_pending=1 on the next edge.
REQ-016: A write with half_pending=1 is a commit; it SHALL be accepted iff full=0, or rd=1 and empty=0 in the same cycle.
REQ-017: An accepted commit SHALL write {staging, w_data} to mem[wr_ptr], increment wr_ptr modulo DEPTH, and clear half_pending.
REQ-018: A rejected commit SHALL leave all state unchanged, and half_pending SHALL stay 1.
REQ-019: A read SHALL be accepted iff empty=0; it increments rd_ptr modulo DEPTH.
REQ-020: A read while empty=1 SHALL be ignored.
REQ-021: r_data SHALL be combinational mem[rd_ptr] (show-ahead) and is valid only while empty=0.
REQ-022: A commit SHALL never bypass to r_data in the same cycle; it becomes readable the cycle after the edge.
REQ-023: count SHALL increment on a commit-only edge, decrement on a read-only edge, and hold when both or neither occur.
REQ-024: empty SHALL equal (count==0) and full SHALL equal (count==DEPTH), both registered with count.
REQ-025: A read accepted together with a commit while full SHALL keep count=DEPTH and full=1, with both pointers advancing.
REQ-026: A read with empty=1 plus a commit SHALL apply only the commit: count becomes 1 and empty deasserts next cycle.
REQ-027: A staged half-word SHALL never be counted in count and SHALL never be visible on r_data.
REQ-028: Pointer wrap SHALL be natural ADDR_WIDTH-bit overflow; full and empty SHALL be derived from count, not from pointer equality.

Reset
REQ-029: On reset, the block SHALL set rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, half_pending=0, and staging=0.
REQ-030: The storage array SHALL NOT be reset.
REQ-031: Reset SHALL override wr and rd in the same cycle.
REQ-032: Reset mid-operation SHALL discard any staged half-word and all committed words.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4)
REQ-033: Write 0xA then 0x5, then idle one cycle -> r_data=0xA5, count=1, empty=0, half_pending=0; rd=1 -> empty=1, count=0 next cycle.
REQ-034: 8 half-word writes 0x1..0x8 -> full=1, count=4; a 9th write 0x9 is accepted, half_pending=1; a 10th write 0xA is rejected, state unchanged.
REQ-035: From the REQ-034 end state, rd=1 and wr=1 with 0xA -> r_data steps from 0x12 to 0x34, count stays 4, full=1, half_pending=0; the last pop then returns 0x9A.
REQ-036: rd=1 with empty=1 and a commit of 0xC,0xD -> no underflow, count=1, r_data=0xCD the cycle after the commit.
REQ-037: Stage 0xF (half_pending=1) then assert reset for one cycle -> half_pending=0, empty=1, count=0; next writes 0x3,0x4 -> r_data=0x34, with no 0xF leakage.
REQ-038: 20 words streamed with interleaved rd and wr across pointer wrap -> output order matches input order, and empty/full flags match a reference-model count every cycle.
